gcm_ghash_multi: RTL
====================

# gcm_ghash_multi

Parametrised, multi-channel GHASH/tag engine for the AES-GCM datapath. It accepts AAD and ciphertext blocks that the AES pipeline tags with a channel number. It keeps a separate hash state and length counters for each channel, and uses one shared digit-serial GF(2^128) multiplier for all channels. On a FINAL command it produces the 128-bit tag for that channel. It replaces the fixed single-instance tag stages at the tail of the pipeline.

## Interface
Parameters:
- CHANNELS, 4: number of independent GCM instances; power of two, ≥1.
- DIGIT_BITS, 8: multiplier bits processed per cycle; must divide 128. The multiply latency is M = 128/DIGIT_BITS cycles.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  command valid.
- o_ready  out  1  engine can accept a command this cycle.
- i_cmd  in  2  command: 0 INIT, 1 AAD, 2 CT, 3 FINAL.
- i_chan  in  max(1,log2 CHANNELS)  target channel.
- i_data  in  [0:127]  for INIT: H; for AAD/CT: the block; for FINAL: ignored.
- i_ej0  in  [0:127]  E(K,J0); sampled only on INIT.
- i_bytes  in  5  valid bytes in the block, 1..16, left-aligned. The engine zeroes bytes from i_bytes..15 itself. 0 is treated as 16.
- o_tag_valid  out  1  one-cycle tag strobe.
- o_tag_chan  out  log2 width  channel of o_tag.
- o_tag  out  [0:127]  GHASH result XOR E(K,J0).
- o_err  out  1  one-cycle strobe: command rejected.

## Operation
- Accept a command when i_valid && o_ready. o_ready is 1 only in state IDLE and not in reset.
- Per-channel state: H, EJ0, Y (accumulator), alen[63:0], clen[63:0], active, ct_seen.
- INIT:
  - Loads H and EJ0.
  - Clears Y, alen, clen and ct_seen.
  - Sets active=1.
  - Allowed on an active channel (restarts it).
- AAD:
  - Computes Y = (Y ⊕ pad(i_data)) · H.
  - Adds 8·i_bytes to alen, modulo 2^64.
- CT: same as AAD but adds to clen and sets ct_seen.
- FINAL:
  - Computes Y = (Y ⊕ (alen‖clen)) · H.
  - Then o_tag = Y ⊕ EJ0, and the channel is marked inactive.
- Errors:
  - AAD/CT/FINAL on an inactive channel, or AAD while ct_seen=1, pulses o_err on the cycle after acceptance.
  - A rejected command leaves the channel state unchanged and the engine stays in IDLE.
- GF(2^128) follows GCM bit order: index 0 is the coefficient of x^0. R = 0xE1‖0^120.
- Multiply algorithm, for i = 0..127:
  - If X[i], then Z ^= V.
  - V = V[127] ? (V>>1) ⊕ R : V>>1.
  - DIGIT_BITS iterations are unrolled per cycle, consuming X from index 0 upward.
- FSM states:
  - IDLE: AAD/CT accepted → MUL. FINAL accepted → MUL with fin=1. INIT or error → IDLE.
  - MUL: a counter runs 0..M−1. At M−1, write Y back; if fin=0 go to IDLE, else go to TAG.
  - TAG: drive o_tag_valid with o_tag/o_tag_chan, clear active, go to IDLE.
- Other channels' state is never touched by a command on a given channel.

## Timing
- Reset values: o_ready=0 during reset and 1 on the first cycle after rst deasserts. o_tag_valid=0, o_tag=0, o_tag_chan=0, o_err=0.
- Reset state: FSM=IDLE; every channel has active=0, Y=0, alen=clen=0, ct_seen=0.
- rst asserted mid-multiply aborts the operation; no tag is produced.
- Command accepted at cycle N:
  - INIT: state updated at N+1; o_ready=1 at N+1.
  - AAD/CT: o_ready=0 for N+1..N+M; Y is updated at the end of N+M; o_ready=1 at N+M+1.
  - FINAL: o_tag_valid=1 at N+M+1 only; o_ready=1 at N+M+2.
  - Error: o_err=1 at N+1; o_ready stays 1.
- o_tag and o_tag_chan hold their value after the strobe until the next tag.
- Length counters wrap silently at 2^64.
- i_valid while o_ready=0 is ignored. The source must hold the command until it is accepted.

## Test plan
- Empty message, DIGIT_BITS=8:
  - Stimulus: INIT ch0 with H=66e94bd4ef8a2c3b884cfa59ca342b2e and EJ0=58e2fccefa7e3061367f1d57a4e7455a, then FINAL ch0.
  - Required: o_tag=58e2fccefa7e3061367f1d57a4e7455a exactly 17 cycles after FINAL is accepted.
- NIST test case 2:
  - Stimulus: same INIT, then CT 0388dace60b6a392f328c2b971b2fe78 with i_bytes=16, then FINAL.
  - Required: o_tag=ab6e47d42cec13bdf53a67b21257bddf.
  - Repeat with DIGIT_BITS=1, 4, 32, 128: same tag, with latencies M=128, 32, 4, 1.
- Interleaving:
  - Stimulus: test case 2 on ch1 and the empty message on ch3, with commands alternated.
  - Required: both tags are correct and o_tag_chan=1 and 3 respectively.
- Errors:
  - AAD after CT on a channel → o_err at N+1 and the final tag is unchanged (still ab6e…bddf).
  - FINAL on an uninitialised channel → o_err and no o_tag_valid.
- Reset:
  - Stimulus: assert rst in the middle of a FINAL multiply.
  - Required: no o_tag_valid; o_ready=1 one cycle after release; a subsequent FINAL on that channel raises o_err.

Source files
------------

// File: rtl/gcm_ghash_multi_if.sv
// Command and tag bus of the multi-channel GHASH/tag engine.
// master = command source / tag sink, slave = the engine.
interface gcm_ghash_multi_if #(
  parameter int unsigned CHAN_W = 2
);
  logic              i_valid;
  logic              o_ready;
  logic [1:0]        i_cmd;
  logic [CHAN_W-1:0] i_chan;
  logic [0:127]      i_data;
  logic [0:127]      i_ej0;
  logic [4:0]        i_bytes;
  logic              o_tag_valid;
  logic [CHAN_W-1:0] o_tag_chan;
  logic [0:127]      o_tag;
  logic              o_err;

  modport master (
    output i_valid, i_cmd, i_chan, i_data, i_ej0, i_bytes,
    input  o_ready, o_tag_valid, o_tag_chan, o_tag, o_err
  );

  modport slave (
    input  i_valid, i_cmd, i_chan, i_data, i_ej0, i_bytes,
    output o_ready, o_tag_valid, o_tag_chan, o_tag, o_err
  );
endinterface

// File: rtl/gcm_ghash_multi.sv
// Multi-channel GHASH/tag engine: per-channel hash state and lengths sharing one
// digit-serial GF(2^128) multiplier; FINAL emits GHASH xor E(K,J0).
module gcm_ghash_multi #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DIGIT_BITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  gcm_ghash_multi_if.slave   bus
);
  localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned M      = 128 / DIGIT_BITS;
  localparam int unsigned CNT_W  = (M > 1) ? $clog2(M) : 1;
  localparam logic [0:127] R_POLY = {8'hE1, 120'h0};

  localparam logic [1:0] CMD_INIT = 2'd0;
  localparam logic [1:0] CMD_AAD  = 2'd1;
  localparam logic [1:0] CMD_CT   = 2'd2;
  localparam logic [1:0] CMD_FIN  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_TAG} state_e;

  state_e              state_q;
  logic                ready_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                fin_q;
  logic [CHAN_W-1:0]   chan_q;
  logic [0:127]        x_q, z_q, v_q;
  logic [0:127]        z_d, v_d;
  logic                tag_valid_q, err_q;
  logic [0:127]        tag_q;
  logic [CHAN_W-1:0]   tag_chan_q;

  logic [0:127]        h_q     [CHANNELS];
  logic [0:127]        ej0_q   [CHANNELS];
  logic [0:127]        y_q     [CHANNELS];
  logic [63:0]         alen_q  [CHANNELS];
  logic [63:0]         clen_q  [CHANNELS];
  logic [CHANNELS-1:0] active_q;
  logic [CHANNELS-1:0] ct_seen_q;

  logic                accept_c;
  logic                cmd_err_c;
  logic [4:0]          nb_c;
  logic [7:0]          nbits_c;
  logic [0:127]        mask_c;
  logic [0:127]        blk_c;
  logic [CHAN_W-1:0]   ch;

  assign ch       = bus.i_chan;
  assign accept_c = bus.i_valid && bus.o_ready;

  // Command decode: error check, byte masking and the operand folded into Y.
  always_comb begin
    nb_c      = (bus.i_bytes == 5'd0 || bus.i_bytes > 5'd16) ? 5'd16 : bus.i_bytes;
    nbits_c   = {nb_c, 3'b000};
    mask_c    = ~({128{1'b1}} >> nbits_c);
    cmd_err_c = (bus.i_cmd != CMD_INIT) &&
                (!active_q[ch] || (bus.i_cmd == CMD_AAD && ct_seen_q[ch]));
    blk_c     = (bus.i_cmd == CMD_FIN) ? {alen_q[ch], clen_q[ch]} : (bus.i_data & mask_c);
  end

  // One digit of the shift-and-add multiply; X is consumed from index 0 upward.
  always_comb begin
    z_d = z_q;
    v_d = v_q;
    for (int unsigned b = 0; b < DIGIT_BITS; b++) begin
      if (x_q[7'(b)]) z_d = z_d ^ v_d;
      v_d = v_d[127] ? ((v_d >> 1) ^ R_POLY) : (v_d >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      cnt_q       <= '0;
      fin_q       <= 1'b0;
      chan_q      <= '0;
      x_q         <= '0;
      z_q         <= '0;
      v_q         <= '0;
      tag_valid_q <= 1'b0;
      err_q       <= 1'b0;
      tag_q       <= '0;
      tag_chan_q  <= '0;
      h_q         <= '{default: '0};
      ej0_q       <= '{default: '0};
      y_q         <= '{default: '0};
      alen_q      <= '{default: '0};
      clen_q      <= '{default: '0};
      active_q    <= '0;
      ct_seen_q   <= '0;
    end else begin
      tag_valid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            if (cmd_err_c) begin
              err_q <= 1'b1;
            end else if (bus.i_cmd == CMD_INIT) begin
              h_q[ch]       <= bus.i_data;
              ej0_q[ch]     <= bus.i_ej0;
              y_q[ch]       <= '0;
              alen_q[ch]    <= '0;
              clen_q[ch]    <= '0;
              ct_seen_q[ch] <= 1'b0;
              active_q[ch]  <= 1'b1;
            end else begin
              x_q     <= y_q[ch] ^ blk_c;
              z_q     <= '0;
              v_q     <= h_q[ch];
              cnt_q   <= '0;
              chan_q  <= ch;
              fin_q   <= (bus.i_cmd == CMD_FIN);
              ready_q <= 1'b0;
              state_q <= S_MUL;
              if (bus.i_cmd == CMD_AAD) alen_q[ch] <= alen_q[ch] + 64'(nbits_c);
              if (bus.i_cmd == CMD_CT) begin
                clen_q[ch]    <= clen_q[ch] + 64'(nbits_c);
                ct_seen_q[ch] <= 1'b1;
              end
            end
          end
        end
        S_MUL: begin
          x_q   <= x_q << DIGIT_BITS;
          z_q   <= z_d;
          v_q   <= v_d;
          cnt_q <= CNT_W'(cnt_q + 1'b1);
          if (cnt_q == CNT_W'(M - 1)) begin
            y_q[chan_q] <= z_d;
            if (fin_q) begin
              tag_valid_q <= 1'b1;
              tag_q       <= z_d ^ ej0_q[chan_q];
              tag_chan_q  <= chan_q;
              state_q     <= S_TAG;
            end else begin
              ready_q <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        S_TAG: begin
          active_q[chan_q] <= 1'b0;
          ready_q          <= 1'b1;
          state_q          <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready     = ready_q && !rst;
  assign bus.o_tag_valid = tag_valid_q;
  assign bus.o_tag       = tag_q;
  assign bus.o_tag_chan  = tag_chan_q;
  assign bus.o_err       = err_q;
endmodule
